// File: rtl/rv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv_fetch_pkg
// Shared definitions for the uRV instruction fetch stage.
//   RV_RESET_VECTOR    : default PC of the first fetch after reset
//   RV_FETCH_BUF_DEPTH : entries in the fetch-to-decode buffer
//   RV_FETCH_CNT_W     : width of the buffer occupancy count (0..DEPTH)
//   fetch_entry_t      : one buffered instruction, {pc, ir}
//   rv_word_align()    : clears bits [1:0] of an address
// ---------------------------------------------------------------------------
package rv_fetch_pkg;

  localparam logic [31:0] RV_RESET_VECTOR    = 32'h0000_0000;
  localparam int          RV_FETCH_BUF_DEPTH = 2;
  localparam int          RV_FETCH_CNT_W     = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] rv_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_buffer.sv
// ---------------------------------------------------------------------------
// rv_fetch_buffer
// Two-entry FIFO of {pc, ir} sitting between instruction memory returns and
// the decode stage. Entry 0 is always the head; a pop shifts entry 1 down.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   push_i              write {push_pc_i, push_ir_i} at the tail
//   pop_i               discard the head (ignored when empty)
//   flush_i             empty the FIFO; wins over push and pop
//   push_pc_i/push_ir_i data to push
//   head_pc_o/head_ir_o current head entry (stale contents when empty)
//   count_o             occupancy, 0..2
//
// Push and pop in the same cycle are legal at any occupancy. A push while
// full without a pop is an upstream bug and is flagged by an assertion.
// ---------------------------------------------------------------------------
module rv_fetch_buffer
  import rv_fetch_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [31:0]               push_pc_i,
  input  logic [31:0]               push_ir_i,
  output logic [31:0]               head_pc_o,
  output logic [31:0]               head_ir_o,
  output logic [RV_FETCH_CNT_W-1:0] count_o
);

  fetch_entry_t              r_ent0;
  fetch_entry_t              r_ent1;
  logic [RV_FETCH_CNT_W-1:0] r_count;

  logic         w_pop;
  logic         w_full;
  fetch_entry_t w_din;

  assign w_pop  = pop_i && (r_count != '0);
  assign w_full = (r_count == RV_FETCH_CNT_W'(RV_FETCH_BUF_DEPTH));
  assign w_din  = '{pc: push_pc_i, ir: push_ir_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else begin
      case ({push_i, w_pop})
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == '0) begin
            r_ent0 <= w_din;
          end else begin
            r_ent1 <= w_din;
          end
          if (!w_full) begin
            r_count <= r_count + 2'd1;
          end
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever
          // remains after the head leaves.
          if (w_full) begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_din;
          end else begin
            r_ent0 <= w_din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_pc_o = r_ent0.pc;
  assign head_ir_o = r_ent0.ir;
  assign count_o   = r_count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && !w_pop && !flush_i && w_full));

endmodule

// File: rtl/rv_fetch.sv
// ---------------------------------------------------------------------------
// rv_fetch
// Instruction fetch stage of the uRV pipeline. Owns the program counter,
// issues single-word reads to instruction memory (at most one in flight),
// buffers returned words and hands them to decode.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   f_stall_i          decode cannot take the presented instruction
//   x_bra_i            one-cycle redirect strobe from execute
//   x_bra_target_i     redirect target (bits [1:0] ignored)
//   im_addr_o          fetch address, word aligned
//   im_rd_o            one-cycle read strobe
//   im_data_i          returned instruction word
//   im_valid_i         return strobe, in order, latency >= 1
//   f_ir_o / f_pc_o    instruction and its PC for decode
//   f_valid_o          f_ir_o / f_pc_o valid
//
// Decode handshake: an instruction is transferred in every cycle where
// f_valid_o = 1 and f_stall_i = 0. While f_stall_i = 1 the presented
// instruction holds. A redirect empties the buffer regardless of stall.
//
// Redirects that land while a read is in flight cannot cancel the memory
// access, so the read is marked for discard and the stage waits for its
// return before fetching at the new target.
// ---------------------------------------------------------------------------
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RV_RESET_VECTOR
)(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  // IDLE covers only the first cycle after reset release.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic        r_outstanding;
  logic        r_discard;

  logic                      w_ret;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_issue;
  logic [2:0]                w_occ_next;
  logic [RV_FETCH_CNT_W-1:0] w_count;
  logic [31:0]               w_head_pc;
  logic [31:0]               w_head_ir;

  // A return only counts when we are actually waiting for one; returns for
  // requests killed by reset find outstanding = 0 and are dropped here.
  assign w_ret  = im_valid_i && r_outstanding;
  assign w_push = w_ret && !r_discard && !x_bra_i;
  assign w_pop  = f_valid_o && !f_stall_i;

  assign w_occ_next = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};

  // The strobe reacts to this cycle's return so that a 1-cycle memory can
  // sustain one fetch per cycle. Space is checked after this cycle's
  // push/pop so the response to this read always has a slot.
  assign w_issue = (r_state == ST_RUN) && !x_bra_i &&
                   (!r_outstanding || w_push) &&
                   (w_occ_next < 3'(RV_FETCH_BUF_DEPTH));

  assign im_rd_o   = w_issue;
  assign im_addr_o = r_fetch_pc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= rv_word_align(RESET_VECTOR);
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_state <= ST_RUN;
      if (x_bra_i) begin
        r_fetch_pc <= rv_word_align(x_bra_target_i);
        if (r_outstanding && !im_valid_i) begin
          r_discard <= 1'b1;
        end else begin
          r_outstanding <= 1'b0;
          r_discard     <= 1'b0;
        end
      end else if (w_issue) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end else if (w_ret) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
    end
  end

  rv_fetch_buffer u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push_i    (w_push),
    .pop_i     (w_pop),
    .flush_i   (x_bra_i),
    .push_pc_i (r_req_pc),
    .push_ir_i (im_data_i),
    .head_pc_o (w_head_pc),
    .head_ir_o (w_head_ir),
    .count_o   (w_count)
  );

  assign f_valid_o = (w_count != '0);
  assign f_pc_o    = w_head_pc;
  assign f_ir_o    = w_head_ir;

endmodule
